// File: rtl/sram_mp_pkg.sv
// ----------------------------------------------------------------------------
// sram_mp_pkg
//   Shared definitions for the multi-port SRAM: clear/ready state encoding and
//   the read-during-write collision mode of the current build.
//   Optional feature macro: SRAM_BYPASS_EN (write-first forwarding on reads).
// ----------------------------------------------------------------------------
package sram_mp_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } sram_state_e;

  localparam int COLLIDE_READ_FIRST  = 0;
  localparam int COLLIDE_WRITE_FIRST = 1;

`ifdef SRAM_BYPASS_EN
  localparam int SRAM_COLLIDE_MODE = COLLIDE_WRITE_FIRST;
`else
  localparam int SRAM_COLLIDE_MODE = COLLIDE_READ_FIRST;
`endif

endpackage

// File: rtl/sram_mp_rd_port.sv
// ----------------------------------------------------------------------------
// sram_mp_rd_port
//   One registered read port of sram_mp: range check, optional write-first
//   forwarding, and the rd_data / rd_valid output registers.
//   Optional feature macro: SRAM_BYPASS_EN.
// Ports
//   i_clk, i_rst     clock, synchronous active-high reset
//   i_ready          array is cleared and accepting accesses
//   i_rd_en          read request for this port
//   i_rd_addr        read address
//   i_arr_word       array word at i_rd_addr (0 when out of range)
//   i_wr_ok          a write is being committed this cycle
//   i_wr_addr/data/be  the committed write, used only for forwarding
//   o_in_range       i_rd_addr < DEPTH (parent gates its array lookup with it)
//   o_rd_data        registered read data
//   o_rd_valid       one-cycle valid pulse
// ----------------------------------------------------------------------------
module sram_mp_rd_port import sram_mp_pkg::*; #(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 256,
  parameter int BYTE_W     = 8,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int NBYTES     = WIDTH / BYTE_W
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_ready,
  input  logic                  i_rd_en,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr,
  input  logic [WIDTH-1:0]      i_arr_word,
  input  logic                  i_wr_ok,
  input  logic [ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [WIDTH-1:0]      i_wr_data,
  input  logic [NBYTES-1:0]     i_wr_be,
  output logic                  o_in_range,
  output logic [WIDTH-1:0]      o_rd_data,
  output logic                  o_rd_valid
);

  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);

  logic             w_in_range;
  logic             w_take;
  logic [WIDTH-1:0] w_word;
  logic [WIDTH-1:0] r_rd_data;
  logic             r_rd_valid;

  assign w_in_range = ({1'b0, i_rd_addr} < DEPTH_W);
  assign w_take     = i_ready & i_rd_en;
  assign o_in_range = w_in_range;

`ifdef SRAM_BYPASS_EN
  // Write-first: lanes being written this cycle come from the write bus.
  always_comb begin
    w_word = i_arr_word;
    if (i_wr_ok && (i_wr_addr == i_rd_addr)) begin
      for (int i = 0; i < NBYTES; i++) begin
        if (i_wr_be[i]) w_word[i*BYTE_W +: BYTE_W] = i_wr_data[i*BYTE_W +: BYTE_W];
      end
    end
  end
`else
  // Read-first: the array still holds the old word at the sampling edge.
  logic w_unused_wr;
  assign w_unused_wr = ^{i_wr_ok, i_wr_addr, i_wr_data, i_wr_be};
  assign w_word      = i_arr_word;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_rd_valid <= w_take;
      if (w_take) r_rd_data <= w_in_range ? w_word : '0;
    end
  end

  assign o_rd_data  = r_rd_data;
  assign o_rd_valid = r_rd_valid;

endmodule

// File: rtl/sram_mp.sv
// ----------------------------------------------------------------------------
// sram_mp
//   Multi-port synchronous SRAM: one byte-maskable write port, RD_PORTS
//   registered read ports. After reset every word is overwritten with
//   CLEAR_VAL (one word per cycle, busy high meanwhile), so no memory
//   initialisation file is needed.
//   Optional feature macro: SRAM_BYPASS_EN (read-during-write returns the
//   new word; default build returns the old word).
// Ports
//   i_clk       clock
//   i_rst       synchronous active-high reset; restarts the clear
//   o_busy      clear in progress, all accesses ignored
//   i_wr_en     write request
//   i_wr_addr   write address
//   i_wr_data   write data
//   i_wr_be     byte-lane enables
//   i_rd_en     per-port read request
//   i_rd_addr   port p address at [p*ADDR_WIDTH +: ADDR_WIDTH]
//   o_rd_data   port p data at [p*WIDTH +: WIDTH], registered
//   o_rd_valid  per-port one-cycle valid
// ----------------------------------------------------------------------------
module sram_mp import sram_mp_pkg::*; #(
  parameter int               WIDTH      = 32,
  parameter int               DEPTH      = 256,
  parameter int               RD_PORTS   = 2,
  parameter int               BYTE_W     = 8,
  parameter logic [WIDTH-1:0] CLEAR_VAL  = '0,
  parameter int               ADDR_WIDTH = $clog2(DEPTH),
  parameter int               NBYTES     = WIDTH / BYTE_W
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  output logic                         o_busy,
  input  logic                         i_wr_en,
  input  logic [ADDR_WIDTH-1:0]        i_wr_addr,
  input  logic [WIDTH-1:0]             i_wr_data,
  input  logic [NBYTES-1:0]            i_wr_be,
  input  logic [RD_PORTS-1:0]          i_rd_en,
  input  logic [RD_PORTS*ADDR_WIDTH-1:0] i_rd_addr,
  output logic [RD_PORTS*WIDTH-1:0]    o_rd_data,
  output logic [RD_PORTS-1:0]          o_rd_valid
);

  localparam logic [ADDR_WIDTH:0]   DEPTH_W   = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  sram_state_e           r_state;
  logic [ADDR_WIDTH-1:0] r_clr_cnt;
  logic                  r_busy;
  logic [WIDTH-1:0]      r_mem [DEPTH];

  logic w_ready;
  logic w_wr_ok;

  assign w_ready = (r_state == ST_READY);
  assign w_wr_ok = w_ready && i_wr_en && ({1'b0, i_wr_addr} < DEPTH_W);
  assign o_busy  = r_busy;

  // Clear sequencer: busy drops on the same edge that writes the last word.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= ST_CLEAR;
      r_clr_cnt <= '0;
      r_busy    <= 1'b1;
    end else begin
      case (r_state)
        ST_CLEAR: begin
          if (r_clr_cnt == LAST_ADDR) begin
            r_state <= ST_READY;
            r_busy  <= 1'b0;
          end else begin
            r_clr_cnt <= r_clr_cnt + 1'b1;
          end
        end
        default: r_busy <= 1'b0;
      endcase
    end
  end

  // Array has no reset of its own; the clear sequence owns the write port
  // until it finishes.
  always_ff @(posedge i_clk) begin
    if (!i_rst && (r_state == ST_CLEAR)) begin
      r_mem[r_clr_cnt] <= CLEAR_VAL;
    end else if (!i_rst && w_wr_ok) begin
      for (int i = 0; i < NBYTES; i++) begin
        if (i_wr_be[i]) r_mem[i_wr_addr][i*BYTE_W +: BYTE_W] <= i_wr_data[i*BYTE_W +: BYTE_W];
      end
    end
  end

  for (genvar p = 0; p < RD_PORTS; p++) begin : g_rd
    logic [ADDR_WIDTH-1:0] w_addr;
    logic                  w_in_range;
    logic [WIDTH-1:0]      w_arr;

    assign w_addr = i_rd_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
    // Never index past the array when DEPTH is not a power of two.
    assign w_arr  = w_in_range ? r_mem[w_addr] : '0;

    sram_mp_rd_port #(
      .WIDTH      (WIDTH),
      .DEPTH      (DEPTH),
      .BYTE_W     (BYTE_W),
      .ADDR_WIDTH (ADDR_WIDTH),
      .NBYTES     (NBYTES)
    ) u_port (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_ready    (w_ready),
      .i_rd_en    (i_rd_en[p]),
      .i_rd_addr  (w_addr),
      .i_arr_word (w_arr),
      .i_wr_ok    (w_wr_ok),
      .i_wr_addr  (i_wr_addr),
      .i_wr_data  (i_wr_data),
      .i_wr_be    (i_wr_be),
      .o_in_range (w_in_range),
      .o_rd_data  (o_rd_data[p*WIDTH +: WIDTH]),
      .o_rd_valid (o_rd_valid[p])
    );
  end

endmodule

// File: tb/tb_sram_mp.sv
// ----------------------------------------------------------------------------
// tb_sram_mp
//   Two instances share one stimulus stream: A (DEPTH 256, clear value 0) and
//   B (DEPTH 200, clear value 0x5A5A5A5A). Each has a word-array model; reads
//   push their expected word into a per-port queue and a negedge monitor pops
//   and compares whenever the port should present data.
// ----------------------------------------------------------------------------
module tb_sram_mp;
  import sram_mp_pkg::*;

  localparam int W = 32;
  localparam int NP = 2;
  localparam int AW = 8;
  localparam int NB = 4;
  localparam int DEP_A = 256;
  localparam int DEP_B = 200;
  localparam logic [31:0] CLR_A = 32'h0000_0000;
  localparam logic [31:0] CLR_B = 32'h5A5A_5A5A;

  typedef struct {
    int          due;
    logic [31:0] data;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [W-1:0]  wr_data;
  logic [NB-1:0] wr_be;
  logic [NP-1:0] rd_en;
  logic [NP*AW-1:0] rd_addr;

  logic          busy_a, busy_b;
  logic [NP*W-1:0] rd_data_a, rd_data_b;
  logic [NP-1:0] rd_valid_a, rd_valid_b;

  logic [31:0] model [2][256];
  int          clr_done [2];
  int          edge_n = 0;
  bit          started = 1'b0;
  logic [31:0] last [4];
  exp_t        q [4][$];
  int          n_checks = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  sram_mp #(.WIDTH(W), .DEPTH(DEP_A), .RD_PORTS(NP), .BYTE_W(8), .CLEAR_VAL(CLR_A)) dut_a (
    .i_clk(clk), .i_rst(rst), .o_busy(busy_a), .i_wr_en(wr_en), .i_wr_addr(wr_addr),
    .i_wr_data(wr_data), .i_wr_be(wr_be), .i_rd_en(rd_en), .i_rd_addr(rd_addr),
    .o_rd_data(rd_data_a), .o_rd_valid(rd_valid_a));

  sram_mp #(.WIDTH(W), .DEPTH(DEP_B), .RD_PORTS(NP), .BYTE_W(8), .CLEAR_VAL(CLR_B)) dut_b (
    .i_clk(clk), .i_rst(rst), .o_busy(busy_b), .i_wr_en(wr_en), .i_wr_addr(wr_addr),
    .i_wr_data(wr_data), .i_wr_be(wr_be), .i_rd_en(rd_en), .i_rd_addr(rd_addr),
    .o_rd_data(rd_data_b), .o_rd_valid(rd_valid_b));

  function automatic int dep(input int d);
    return (d == 0) ? DEP_A : DEP_B;
  endfunction

  function automatic logic [31:0] clr_val(input int d);
    return (d == 0) ? CLR_A : CLR_B;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  // Reference behaviour for one clock edge, evaluated on the inputs as driven.
  task automatic step();
    for (int d = 0; d < 2; d++) begin
      if (!rst && clr_done[d] >= dep(d)) begin
        for (int p = 0; p < NP; p++) begin
          if (rd_en[p]) begin
            exp_t e;
            int   a;
            a = int'(rd_addr[p*AW +: AW]);
            e.due = edge_n + 1;
            if (a >= dep(d)) begin
              e.data = 32'h0;
            end else begin
              e.data = model[d][a];
              if (SRAM_COLLIDE_MODE == COLLIDE_WRITE_FIRST && wr_en && int'(wr_addr) == a) begin
                for (int i = 0; i < NB; i++)
                  if (wr_be[i]) e.data[i*8 +: 8] = wr_data[i*8 +: 8];
              end
            end
            q[d*NP+p].push_back(e);
          end
        end
        if (wr_en && int'(wr_addr) < dep(d)) begin
          for (int i = 0; i < NB; i++)
            if (wr_be[i]) model[d][wr_addr][i*8 +: 8] = wr_data[i*8 +: 8];
        end
      end
    end
    @(posedge clk);
    #1;
    edge_n++;
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        clr_done[d] = 0;
        for (int a = 0; a < 256; a++) model[d][a] = clr_val(d);
        for (int p = 0; p < NP; p++) last[d*NP+p] = 32'h0;
      end else begin
        clr_done[d]++;
      end
    end
  endtask

  task automatic idle();
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_be = '0;
    rd_en = '0; rd_addr = '0;
  endtask

  function automatic logic [AW-1:0] pick_addr();
    case ($urandom_range(0, 3))
      0:       return AW'($urandom_range(195, 205));
      1:       return AW'($urandom_range(16, 19));
      default: return AW'($urandom_range(0, 255));
    endcase
  endfunction

  task automatic rand_cycle();
    wr_en   = 1'($urandom_range(0, 1));
    wr_addr = pick_addr();
    wr_data = $urandom;
    wr_be   = NB'($urandom);
    rd_en   = NP'($urandom);
    for (int p = 0; p < NP; p++)
      rd_addr[p*AW +: AW] = ($urandom_range(0, 2) == 0) ? wr_addr : pick_addr();
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] dat, input logic [3:0] be);
    wr_en = 1'b1; wr_addr = a; wr_data = dat; wr_be = be;
  endtask

  // Monitor: busy every cycle, and per port either a due read or a held output.
  always @(negedge clk) begin
    if (started) begin
      for (int d = 0; d < 2; d++) begin
        logic [NP*W-1:0] rdv;
        logic [NP-1:0]   vv;
        logic            b;
        b   = (d == 0) ? busy_a : busy_b;
        rdv = (d == 0) ? rd_data_a : rd_data_b;
        vv  = (d == 0) ? rd_valid_a : rd_valid_b;
        check($sformatf("busy d%0d", d), {31'b0, b}, {31'b0, (clr_done[d] < dep(d))});
        for (int p = 0; p < NP; p++) begin
          int          idx;
          logic [31:0] dat;
          idx = d * NP + p;
          dat = rdv[p*W +: W];
          if (q[idx].size() > 0 && q[idx][0].due == edge_n) begin
            exp_t e;
            e = q[idx].pop_front();
            check($sformatf("rd_valid d%0d p%0d", d, p), {31'b0, vv[p]}, 32'h1);
            check($sformatf("rd_data d%0d p%0d", d, p), dat, e.data);
            last[idx] = e.data;
          end else begin
            check($sformatf("rd_valid_idle d%0d p%0d", d, p), {31'b0, vv[p]}, 32'h0);
            check($sformatf("rd_hold d%0d p%0d", d, p), dat, last[idx]);
          end
        end
      end
    end
  end

  initial begin
    idle();
    rst = 1'b1;
    step();
    started = 1'b1;
    step();
    rst = 1'b0;

    // Traffic during clear must be ignored; reset again at clear count 100.
    for (int i = 0; i < 100; i++) begin rand_cycle(); step(); end
    rst = 1'b1; idle(); step();
    rst = 1'b0;
    while (clr_done[0] < DEP_A) begin rand_cycle(); step(); end

    // Directed sequence.
    idle(); rd_en = 2'b11; rd_addr = {8'hFF, 8'h00}; step();
    idle(); wr(8'h10, 32'hDEAD_BEEF, 4'hF); step();
    wr(8'h10, 32'h0000_1200, 4'b0010); step();
    idle(); rd_en = 2'b11; rd_addr = {8'h20, 8'h10}; step();
    idle(); step(); step();
    wr(8'h30, 32'hAAAA_AAAA, 4'hF); step();
    wr(8'h30, 32'h1111_1111, 4'hF); rd_en = 2'b11; rd_addr = {8'h30, 8'h30}; step();
    idle(); rd_en = 2'b01; rd_addr = {8'h00, 8'h30}; step();
    idle(); wr(8'h10, 32'hFFFF_FFFF, 4'h0); step();
    idle(); rd_en = 2'b10; rd_addr = {8'h10, 8'h00}; step();
    idle(); wr(8'hC8, 32'hAAAA_AAAA, 4'hF); step();
    idle(); rd_en = 2'b11; rd_addr = {8'hC7, 8'hC8}; step();
    idle(); step();

    // Randomised traffic against the models.
    for (int i = 0; i < 800; i++) begin rand_cycle(); step(); end

    // Reset from READY; contents must come back as the clear value.
    rst = 1'b1; idle(); step();
    rst = 1'b0;
    while (clr_done[0] < DEP_A) begin rand_cycle(); step(); end
    for (int i = 0; i < 100; i++) begin
      idle(); rd_en = NP'($urandom); rd_addr = {pick_addr(), pick_addr()}; step();
    end

    idle(); step(); step(); step();
    for (int k = 0; k < 4; k++) check($sformatf("queue_drain %0d", k), 32'(q[k].size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
